// File: rtl/lsu_exec.sv
// LSU execute stage: consumes one issued load/store uop from the issue queue's
// awake interface, performs the req/gnt/rvalid data-memory transaction and
// broadcasts the result on the LSU CDB slot. Only one uop is in flight at a time.
// Optional: define LSU_MISALIGN_CHK_EN to trap misaligned half/word accesses.
module lsu_exec #(
  parameter int unsigned PR_W  = 6,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_lsu,
  input  logic             ready_awake,
  input  logic [PR_W-1:0]  Px_awake,
  input  logic [31:0]      Addr_awake,
  input  logic [3:0]       Conf_awake,
  input  logic             RegWr_awake,
  input  logic [TAG_W-1:0] tag_rob_awake,
  input  logic             has_excp_awake,
  output logic             stall_lsuq,
  output logic [PR_W-1:0]  Prd_lsu,
  input  logic [31:0]      data_prd_lsu,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             ready_lsu,
  output logic             RegWr_lsu,
  output logic [PR_W-1:0]  Pd_lsu,
  output logic [31:0]      data_lsu,
  output logic [TAG_W-1:0] tag_rob_lsu,
  output logic             excp_lsu
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StWb, StDrain} state_e;

  state_e            state_q;
  logic [PR_W-1:0]   px_q;
  logic [31:0]       addr_q;
  logic [2:0]        conf_q;
  logic              regwr_q;
  logic [TAG_W-1:0]  tag_q;
  logic              excp_q;
  logic [31:0]       result_q;

  // Conf[3] is reserved and intentionally ignored.
  logic unused_conf;
  assign unused_conf = Conf_awake[3];

  logic misalign;
  logic trap;
`ifdef LSU_MISALIGN_CHK_EN
  // Half needs a[0]==0, word needs a[1:0]==0.
  always_comb begin
    misalign = 1'b0;
    if (Conf_awake[1:0] == 2'b01) misalign = Addr_awake[0];
    if (Conf_awake[1:0] == 2'b10) misalign = |Addr_awake[1:0];
  end
`else
  assign misalign = 1'b0;
`endif
  assign trap = has_excp_awake | (Conf_awake[1:0] == 2'b11) | misalign;

  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // Byte strobes and lane-replicated store data for the held uop.
  always_comb begin
    strb  = 4'b1111;
    wdata = data_prd_lsu;
    unique case (conf_q[1:0])
      2'b00: begin
        strb  = 4'b0001 << addr_q[1:0];
        wdata = {4{data_prd_lsu[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << addr_q[1:0];
        wdata = {2{data_prd_lsu[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and sign/zero extension of returned load data; conf[2] = unsigned.
  always_comb begin
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    load_ext = shifted;
    unique case (conf_q[1:0])
      2'b00:   load_ext = {{24{~conf_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~conf_q[2] & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // Control FSM plus uop capture; flush overrides normal sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      px_q     <= '0;
      addr_q   <= '0;
      conf_q   <= '0;
      regwr_q  <= 1'b0;
      tag_q    <= '0;
      excp_q   <= 1'b0;
      result_q <= '0;
    end else if (flush_lsu) begin
      unique case (state_q)
        // A granted store is committed traffic; a granted load must drain its rvalid.
        StReq:   state_q <= (mem_gnt && regwr_q) ? StDrain : StIdle;
        StWait:  state_q <= mem_rvalid ? StIdle : StDrain;
        StDrain: state_q <= mem_rvalid ? StIdle : StDrain;
        default: state_q <= StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ready_awake) begin
            px_q     <= Px_awake;
            addr_q   <= Addr_awake;
            conf_q   <= Conf_awake[2:0];
            regwr_q  <= RegWr_awake;
            tag_q    <= tag_rob_awake;
            excp_q   <= trap;
            result_q <= '0;
            state_q  <= trap ? StWb : StReq;
          end
        end
        StReq: begin
          if (mem_gnt) state_q <= regwr_q ? StWait : StWb;
        end
        StWait: begin
          if (mem_rvalid) begin
            result_q <= load_ext;
            state_q  <= StWb;
          end
        end
        StWb:    state_q <= StIdle;
        StDrain: if (mem_rvalid) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic in_req;
  logic in_wb;

  // Output decode from state and captured registers.
  always_comb begin
    in_req      = (state_q == StReq);
    in_wb       = (state_q == StWb);
    stall_lsuq  = (state_q != StIdle) | ready_awake;
    Prd_lsu     = px_q;
    mem_req     = in_req;
    mem_we      = in_req & ~regwr_q;
    mem_addr    = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wstrb   = in_req ? strb : 4'd0;
    mem_wdata   = in_req ? wdata : 32'd0;
    ready_lsu   = in_wb & ~flush_lsu;
    RegWr_lsu   = in_wb & regwr_q & ~excp_q;
    Pd_lsu      = in_wb ? px_q : '0;
    data_lsu    = in_wb ? result_q : 32'd0;
    tag_rob_lsu = in_wb ? tag_q : '0;
    excp_lsu    = in_wb & excp_q;
  end

endmodule
